// File: rtl/unidade_controle_if.sv
// Bundles the control-unit handshake with the instruction source and the
// control lines it drives into the shared-bus datapath.
interface unidade_controle_if #(
    parameter int CNT_W = 8
);
    logic             run;
    logic [8:0]       ir;
    logic             ir_in;
    logic [7:0]       r_in;
    logic [7:0]       r_out;
    logic             g_out;
    logic             din_out;
    logic             a_in;
    logic             g_in;
    logic             add_sub;
    logic             done;
    logic             illegal;
    logic             busy;
    logic [1:0]       step;
    logic [CNT_W-1:0] instr_count;

    // Control unit side: takes the instruction, drives every control line.
    modport master (
        input  run, ir,
        output ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub,
               done, illegal, busy, step, instr_count
    );

    // Datapath / instruction source side.
    modport slave (
        output run, ir,
        input  ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub,
               done, illegal, busy, step, instr_count
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit for the 16-bit register-file processor.
// Handshake: an instruction on ir is accepted on the rising edge where the
// unit is in T0 and run=1 (ir_in marks that cycle); run and ir are ignored
// in every other step. done marks the last step of each instruction.
// step/busy expose the FSM state directly.
module unidade_controle #(
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    unidade_controle_if.master bus
);
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t           state;
    logic [8:0]       ir_q;
    logic [CNT_W-1:0] count_q;

    logic [2:0] opcode;
    logic [2:0] x;
    logic [2:0] y;
    logic       is_arith;

    assign opcode   = ir_q[8:6];
    assign x        = ir_q[5:3];
    assign y        = ir_q[2:0];
    assign is_arith = (opcode[2:1] == 2'b01);

    // Step sequencing, instruction latch and retired-instruction counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= T0;
            ir_q    <= 9'd0;
            count_q <= '0;
        end else begin
            if (bus.done) begin
                count_q <= count_q + 1'b1;
            end
            case (state)
                T0: begin
                    if (bus.run) begin
                        ir_q  <= bus.ir;
                        state <= T1;
                    end
                end
                T1:      state <= is_arith ? T2 : T0;
                T2:      state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Control lines decoded from the current step and latched instruction;
    // reset forces T0, so everything except the run echo is already zero.
    always_comb begin
        bus.ir_in   = 1'b0;
        bus.r_in    = 8'h00;
        bus.r_out   = 8'h00;
        bus.g_out   = 1'b0;
        bus.din_out = 1'b0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.add_sub = 1'b0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        case (state)
            T0: begin
                bus.ir_in = bus.run & resetn;
            end
            T1: begin
                case (opcode)
                    3'b000: begin
                        bus.r_out = 8'h01 << y;
                        bus.r_in  = 8'h01 << x;
                        bus.done  = 1'b1;
                    end
                    3'b001: begin
                        bus.din_out = 1'b1;
                        bus.r_in    = 8'h01 << x;
                        bus.done    = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        bus.r_out = 8'h01 << x;
                        bus.a_in  = 1'b1;
                    end
                    default: begin
                        bus.done    = 1'b1;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_arith) begin
                    bus.r_out   = 8'h01 << y;
                    bus.g_in    = 1'b1;
                    bus.add_sub = ir_q[6];
                end
            end
            default: begin
                if (is_arith) begin
                    bus.g_out = 1'b1;
                    bus.r_in  = 8'h01 << x;
                    bus.done  = 1'b1;
                end
            end
        endcase
    end

    assign bus.busy        = (state != T0);
    assign bus.step        = state;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_unidade_controle.sv
// Directed plus randomized bench for unidade_controle. Each instruction is
// expanded into the list of control words it should produce, one per step,
// and the outputs are compared on the falling edge of every cycle.
module tb_unidade_controle;
    localparam int CNT_W = 8;
    localparam int W     = 23;

    logic clock;
    logic resetn;

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] cnt_m;
    logic [W-1:0]     exp_q[$];

    unidade_controle_if #(.CNT_W(CNT_W)) bus ();

    unidade_controle #(.CNT_W(CNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.master)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control word packing: {r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done, illegal}.
    function automatic logic [W-1:0] rec(input logic [7:0] ri, input logic [7:0] ro,
                                         input logic go, input logic dn, input logic ai,
                                         input logic gi, input logic asb, input logic d,
                                         input logic il);
        return {ri, ro, go, dn, ai, gi, asb, d, il};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.r_in, bus.r_out, bus.g_out, bus.din_out, bus.a_in, bus.g_in,
                bus.add_sub, bus.done, bus.illegal};
    endfunction

    function automatic logic [7:0] bit_of(input logic [2:0] n);
        logic [7:0] v;
        v = 8'h00;
        v[n] = 1'b1;
        return v;
    endfunction

    // Reference: the step-by-step control words an instruction must produce.
    task automatic expand(input logic [8:0] iv);
        logic [2:0] op;
        logic [7:0] rx;
        logic [7:0] ry;
        op = iv[8:6];
        rx = bit_of(iv[5:3]);
        ry = bit_of(iv[2:0]);
        exp_q.delete();
        if (op == 3'd0) begin
            exp_q.push_back(rec(rx, ry, 0, 0, 0, 0, 0, 1, 0));
        end else if (op == 3'd1) begin
            exp_q.push_back(rec(rx, 8'h00, 0, 1, 0, 0, 0, 1, 0));
        end else if (op == 3'd2 || op == 3'd3) begin
            exp_q.push_back(rec(8'h00, rx, 0, 0, 1, 0, 0, 0, 0));
            exp_q.push_back(rec(8'h00, ry, 0, 0, 0, 1, (op == 3'd3), 0, 0));
            exp_q.push_back(rec(rx, 8'h00, 1, 0, 0, 0, 0, 1, 0));
        end else begin
            exp_q.push_back(rec(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        end
    endtask

    // Scoreboard comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Everything that must hold in a cycle, given the expected control word.
    task automatic check_cycle(input string tag, input logic [W-1:0] e, input logic [1:0] st,
                               input logic exp_ir_in);
        check({tag, "_ctrl"}, 32'(observed()), 32'(e));
        check({tag, "_step"}, 32'(bus.step), 32'(st));
        check({tag, "_busy"}, 32'(bus.busy), 32'(st != 2'd0));
        check({tag, "_ir_in"}, 32'(bus.ir_in), 32'(exp_ir_in));
        check({tag, "_count"}, 32'(bus.instr_count), 32'(cnt_m));
        check({tag, "_bus_excl"}, 32'($countones({bus.r_out, bus.g_out, bus.din_out}) <= 1), 32'd1);
    endtask

    // Driver: issue one instruction from T0 and follow it to completion.
    // Entered just after a rising edge with the unit in T0. After acceptance
    // ir is scrambled (it must be ignored) and run is either dropped or held.
    task automatic exec(input string tag, input logic [8:0] iv, input bit hold_run);
        logic [W-1:0] e;
        logic [1:0]   st;
        expand(iv);
        bus.run = 1'b1;
        bus.ir  = iv;
        @(negedge clock);
        check_cycle({tag, "_t0"}, '0, 2'd0, 1'b1);
        @(posedge clock);
        #1;
        bus.run = hold_run;
        bus.ir  = 9'($urandom_range(0, 511));
        st = 2'd1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clock);
            check_cycle($sformatf("%s_t%0d", tag, st), e, st, 1'b0);
            @(posedge clock);
            if (e[1]) cnt_m = cnt_m + 1'b1;
            #1;
            bus.ir = 9'($urandom_range(0, 511));
            st = st + 2'd1;
        end
    endtask

    task automatic idle(input string tag);
        bus.run = 1'b0;
        @(negedge clock);
        check_cycle(tag, '0, 2'd0, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [8:0] iv;
        resetn  = 1'b0;
        bus.run = 1'b1;
        bus.ir  = 9'b010_001_010;
        cnt_m   = '0;

        // Power-on reset: everything quiet, ir_in suppressed even with run=1.
        @(negedge clock);
        check_cycle("por", '0, 2'd0, 1'b0);
        @(posedge clock);
        #1;
        bus.run = 1'b0;
        resetn  = 1'b1;
        idle("por_idle");

        // mvi R2 then mv R5,R2.
        exec("mvi_r2", 9'b001_010_000, 1'b0);
        exec("mv_r5_r2", 9'b000_101_010, 1'b0);
        check("count_after_two", 32'(bus.instr_count), 32'd2);

        // sub R1,R6 and add R1,R6.
        exec("sub_r1_r6", 9'b011_001_110, 1'b0);
        exec("add_r1_r6", 9'b010_001_110, 1'b0);

        // Unsupported opcode and self-move.
        exec("illegal", 9'b111_000_000, 1'b0);
        exec("mv_r3_r3", 9'b000_011_011, 1'b0);
        idle("idle_a");

        // run held high: back-to-back with ir scrambled mid-instruction.
        exec("held_add", 9'b010_111_000, 1'b1);
        exec("held_mvi", 9'b001_100_000, 1'b1);
        exec("held_sub", 9'b011_000_111, 1'b1);
        idle("idle_b");

        // Reset in T2 of an add aborts it at once.
        bus.run = 1'b1;
        bus.ir  = 9'b010_011_100;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("abort_pre_step", 32'(bus.step), 32'd2);
        check("abort_pre_g_in", 32'(bus.g_in), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        cnt_m = '0;
        check_cycle("abort", '0, 2'd0, 1'b0);
        @(posedge clock);
        #1;
        check_cycle("abort_hold", '0, 2'd0, 1'b0);
        bus.run = 1'b0;
        resetn  = 1'b1;
        idle("abort_idle0");
        idle("abort_idle1");

        // 256 moves: counter wraps 255 -> 0.
        for (int i = 0; i < 256; i++) begin
            iv = {3'b000, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            exec("wrap_mv", iv, 1'($urandom_range(0, 1)));
            if (i == 254) check("count_255", 32'(bus.instr_count), 32'd255);
        end
        check("count_wrapped", 32'(bus.instr_count), 32'd0);

        // Random instruction mix, random run holding and idle gaps.
        for (int i = 0; i < 80; i++) begin
            iv = 9'($urandom_range(0, 511));
            exec("rand", iv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle("rand_idle");
        end
        idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 16-bit register-file processor: latches a 9-bit instruction (format III XXX YYY) when `run` is asserted and steps through T0–T3. In each step it drives the one-hot register enables, bus-source selects, A/G enables and the add/sub mode for the shared bus datapath. It sits between the instruction source and the datapath (R0–R7, A, G, bus mux, add/sub unit). Outputs `done` at the end of each instruction and keeps a count of retired instructions.

## Interface
- `CNT_W`, default 8: width of the retired-instruction counter.

- `clock`  in  1  rising-edge system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request; sampled only in T0.
- `ir`  in  9  instruction III XXX YYY; III = opcode, XXX = destination/first operand, YYY = source/second operand.
- `ir_in`  out  1  IR latch strobe; high in T0 when `run`=1.
- `r_in`  out  8  one-hot register write enables; bit n = Rn.
- `r_out`  out  8  one-hot register bus drive; bit n = Rn.
- `g_out`  out  1  G drives the bus.
- `din_out`  out  1  external `din` drives the bus.
- `a_in`  out  1  load A from the bus.
- `g_in`  out  1  load G from the add/sub result.
- `add_sub`  out  1  0 = add, 1 = subtract.
- `done`  out  1  last step of the current instruction.
- `illegal`  out  1  one-cycle pulse; the instruction being retired has an unsupported opcode.
- `busy`  out  1  state is not T0.
- `step`  out  2  current step (0 = T0 … 3 = T3).
- `instr_count`  out  `CNT_W`  number of instructions retired, wraps.

## Operation
- State register has four values: T0, T1, T2, T3. Internal register `ir_q[8:0]` holds the instruction.
- T0 (idle/fetch):
  - `ir_in` = `run`.
  - If `run`=1: `ir_q` <= `ir`, next state T1.
  - Otherwise stay in T0 and hold `ir_q`.
- All other outputs are combinational decodes of state and `ir_q`. X = `ir_q[5:3]`, Y = `ir_q[2:0]`.
- Opcode 000, mv Rx←Ry:
  - T1: `r_out[Y]`, `r_in[X]`, `done`.
  - Next state T0.
- Opcode 001, mvi Rx←din:
  - T1: `din_out`, `r_in[X]`, `done`.
  - Next state T0.
- Opcode 010/011, add/sub Rx←Rx±Ry:
  - T1: `r_out[X]`, `a_in`. Next state T2.
  - T2: `r_out[Y]`, `g_in`; `add_sub` = `ir_q[6]`. Next state T3.
  - T3: `g_out`, `r_in[X]`, `done`. Next state T0.
- Opcodes 100–111:
  - T1: `done`, `illegal`; no enables asserted.
  - Next state T0.
- Bus exclusivity:
  - At most one of the eight `r_out` bits, `g_out` and `din_out` is high in any cycle.
  - All of them are 0 in T0.
- `add_sub` is 0 in every step other than T2.
- X = Y is legal. mv R3,R3 drives `r_out[3]` and `r_in[3]` together.
- `instr_count` increments on every clock edge where `done`=1, illegal instructions included. It wraps from 2^CNT_W−1 to 0.
- `run` outside T0 is ignored. A new instruction is accepted only after returning to T0, so there is no overlap.
- `ir` changing outside T0 has no effect.

## Timing
- While `resetn`=0, regardless of clock:
  - state = T0, `ir_q` = 0, `instr_count` = 0.
  - `ir_in` is forced to 0.
  - Every other output is 0: `r_in`, `r_out`, `g_out`, `din_out`, `a_in`, `g_in`, `add_sub`, `done`, `illegal`, `busy`, `step`.
- Reset released: first evaluated edge occurs in T0.
- Reset asserted mid-instruction aborts it immediately. No `done`, no count increment, and no further enables are driven.
- Latency from the `run` edge in T0 to `done`:
  - mv/mvi/illegal: `done` in the next cycle (2 cycles total).
  - add/sub: `done` 3 cycles later (4 cycles total).
- Throughput: `run` held high gives back-to-back instructions with a single T0 between them.
- Register writes happen at the rising edge that ends the step asserting `r_in`/`a_in`/`g_in`.

## Test plan
- Reset: `resetn`=0 in T2 of an add → immediately all outputs 0 and `step`=0; after release with `run`=0, stays in T0 with `busy`=0.
- mvi R2 then mv R5,R2 (ir=001_010_000, then 000_101_010):
  - mvi T1: `din_out`=1, `r_in`=8'h04.
  - mv T1: `r_out`=8'h04, `r_in`=8'h20.
  - `instr_count`=2.
- sub R1,R6 (ir=011_001_110):
  - T1: `r_out`=8'h02, `a_in`.
  - T2: `r_out`=8'h40, `g_in`, `add_sub`=1.
  - T3: `g_out`, `r_in`=8'h02, `done`.
  - Same sequence with add (010) gives `add_sub`=0.
- Illegal ir=111_000_000 → T1 has `done`=1 and `illegal`=1, `r_in`=`r_out`=0, `instr_count` increments.
- `run` held high, `ir` changed during T2 of an add → executing instruction unaffected; new `ir` latched only at the next T0.
- `CNT_W`=8: run 256 mv instructions → `instr_count` wraps 255→0.
- Every cycle of every test: one-hot/exclusivity check on the bus sources.
